// File: rtl/param_registerfile_stepper.sv
// Combinational +/-1 on a full address pair, flagging when the step rolls over
// (all-ones on increment, zero on decrement).
module addr_stepper #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_value,
  input  logic         i_dir,
  output logic [W-1:0] o_value,
  output logic         o_wrap
);

  assign o_value = i_dir ? (i_value - W'(1)) : (i_value + W'(1));
  assign o_wrap  = i_dir ? (i_value == '0) : (i_value == '1);

endmodule

// File: rtl/param_registerfile.sv
// General register file whose registers pair up into address registers, with
// three read ports, one address read port, and a per-pair increment/decrement.
module param_registerfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int SEL_W  = 3,
  parameter int PSEL_W = 2
) (
  input  logic                CLK,
  input  logic                RST_bar,
  input  logic                MAIN_LOAD_bar,
  input  logic [SEL_W-1:0]    MAIN_LOAD_SEL,
  input  logic [DATA_W-1:0]   MAIN_in,
  input  logic                MAIN_ASSERT_bar,
  input  logic [SEL_W-1:0]    MAIN_ASSERT_SEL,
  output logic [DATA_W-1:0]   MAIN_out,
  input  logic                LHS_ASSERT_bar,
  input  logic [SEL_W-1:0]    LHS_ASSERT_SEL,
  output logic [DATA_W-1:0]   LHS_out,
  input  logic                RHS_ASSERT_bar,
  input  logic [SEL_W-1:0]    RHS_ASSERT_SEL,
  output logic [DATA_W-1:0]   RHS_out,
  input  logic                ADDR_LOAD_bar,
  input  logic [PSEL_W-1:0]   ADDR_LOAD_SEL,
  input  logic [2*DATA_W-1:0] ADDR_in,
  input  logic                ADDR_STEP,
  input  logic                ADDR_DIR,
  input  logic [PSEL_W-1:0]   ADDR_STEP_SEL,
  input  logic                ADDR_ASSERT_bar,
  input  logic [PSEL_W-1:0]   ADDR_ASSERT_SEL,
  output logic [2*DATA_W-1:0] ADDR_out,
  output logic                ADDR_WRAP
);

  localparam int NPAIRS = NREGS / 2;
  localparam int AW     = 2 * DATA_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_wrap;
  logic [DATA_W-1:0] w_next [NREGS];
  logic [AW-1:0]     w_stepIn;
  logic [AW-1:0]     w_stepOut;
  logic              w_stepWrap;
  logic [NPAIRS-1:0] w_stepPair;

  // A step is dropped outright when either load touches any byte of its pair.
  always_comb begin
    w_stepIn   = '0;
    w_stepPair = '0;
    for (int k = 0; k < NPAIRS; k++) begin
      if (ADDR_STEP && (ADDR_STEP_SEL == PSEL_W'(k))) begin
        w_stepIn      = {r_regs[2*k+1], r_regs[2*k]};
        w_stepPair[k] = !((!ADDR_LOAD_bar && (ADDR_LOAD_SEL == PSEL_W'(k))) ||
                          (!MAIN_LOAD_bar && ((MAIN_LOAD_SEL == SEL_W'(2*k)) ||
                                              (MAIN_LOAD_SEL == SEL_W'(2*k+1)))));
      end
    end
  end

  addr_stepper #(.W(AW)) u_stepper (
    .i_value (w_stepIn),
    .i_dir   (ADDR_DIR),
    .o_value (w_stepOut),
    .o_wrap  (w_stepWrap)
  );

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_next[i] = r_regs[i];
      if (!ADDR_LOAD_bar && (ADDR_LOAD_SEL == PSEL_W'(i/2))) begin
        w_next[i] = (i % 2 == 1) ? ADDR_in[AW-1:DATA_W] : ADDR_in[DATA_W-1:0];
      end else if (!MAIN_LOAD_bar && (MAIN_LOAD_SEL == SEL_W'(i))) begin
        w_next[i] = MAIN_in;
      end else if (w_stepPair[i/2]) begin
        w_next[i] = (i % 2 == 1) ? w_stepOut[AW-1:DATA_W] : w_stepOut[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_regs <= w_next;
      r_wrap <= (|w_stepPair) && w_stepWrap;
    end
  end

  assign ADDR_WRAP = r_wrap;

  // Reads see current state only; unmatched or de-asserted selects give zero.
  always_comb begin
    MAIN_out = '0;
    LHS_out  = '0;
    RHS_out  = '0;
    ADDR_out = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (!MAIN_ASSERT_bar && (MAIN_ASSERT_SEL == SEL_W'(i))) MAIN_out = r_regs[i];
      if (!LHS_ASSERT_bar && (LHS_ASSERT_SEL == SEL_W'(i)))   LHS_out  = r_regs[i];
      if (!RHS_ASSERT_bar && (RHS_ASSERT_SEL == SEL_W'(i)))   RHS_out  = r_regs[i];
    end
    for (int k = 0; k < NPAIRS; k++) begin
      if (!ADDR_ASSERT_bar && (ADDR_ASSERT_SEL == PSEL_W'(k))) ADDR_out = {r_regs[2*k+1], r_regs[2*k]};
    end
  end

endmodule

// File: tb/tb_param_registerfile.sv
// Bench for param_registerfile: directed scenarios plus a randomized run, all
// checked against a pair-level reference model held in the bench.
module tb_param_registerfile;

  localparam int DW = 8;
  localparam int NR = 6;
  localparam int SW = 3;
  localparam int PW = 2;
  localparam int NP = NR / 2;

  logic          clock = 1'b0;
  logic          rstBar;
  logic          mainLoadBar, mainAssertBar, lhsAssertBar, rhsAssertBar;
  logic [SW-1:0] mainLoadSel, mainAssertSel, lhsAssertSel, rhsAssertSel;
  logic [DW-1:0] mainIn, mainOut, lhsOut, rhsOut;
  logic          addrLoadBar, addrStep, addrDir, addrAssertBar, addrWrap;
  logic [PW-1:0] addrLoadSel, addrStepSel, addrAssertSel;
  logic [2*DW-1:0] addrIn, addrOut;

  int checks = 0;
  int errors = 0;
  int unsigned mreg [NR];
  bit mwrap;

  param_registerfile #(.DATA_W(DW), .NREGS(NR), .SEL_W(SW), .PSEL_W(PW)) dut (
    .CLK(clock), .RST_bar(rstBar),
    .MAIN_LOAD_bar(mainLoadBar), .MAIN_LOAD_SEL(mainLoadSel), .MAIN_in(mainIn),
    .MAIN_ASSERT_bar(mainAssertBar), .MAIN_ASSERT_SEL(mainAssertSel), .MAIN_out(mainOut),
    .LHS_ASSERT_bar(lhsAssertBar), .LHS_ASSERT_SEL(lhsAssertSel), .LHS_out(lhsOut),
    .RHS_ASSERT_bar(rhsAssertBar), .RHS_ASSERT_SEL(rhsAssertSel), .RHS_out(rhsOut),
    .ADDR_LOAD_bar(addrLoadBar), .ADDR_LOAD_SEL(addrLoadSel), .ADDR_in(addrIn),
    .ADDR_STEP(addrStep), .ADDR_DIR(addrDir), .ADDR_STEP_SEL(addrStepSel),
    .ADDR_ASSERT_bar(addrAssertBar), .ADDR_ASSERT_SEL(addrAssertSel), .ADDR_out(addrOut),
    .ADDR_WRAP(addrWrap)
  );

  always #5 clock = ~clock;

  function automatic int unsigned expReg(int sel);
    return (sel < NR) ? mreg[sel] : 0;
  endfunction

  function automatic int unsigned expPair(int p);
    return (p < NP) ? (mreg[2*p+1] * 256 + mreg[2*p]) : 0;
  endfunction

  // Applies one clock edge's worth of writes: step first, then the
  // higher-priority loads overwrite on top of it.
  task automatic modelEdge();
    int unsigned nr [NR];
    int aPair, mReg, s;
    int unsigned pv, nv;
    bit nw;
    nw = 0;
    for (int i = 0; i < NR; i++) nr[i] = mreg[i];
    aPair = (!addrLoadBar && int'(addrLoadSel) < NP) ? int'(addrLoadSel) : -1;
    mReg  = (!mainLoadBar && int'(mainLoadSel) < NR) ? int'(mainLoadSel) : -1;
    s = int'(addrStepSel);
    if (addrStep && s < NP && s != aPair && !(mReg >= 0 && mReg / 2 == s)) begin
      pv = expPair(s);
      if (addrDir) begin nv = (pv + 65535) % 65536; nw = (pv == 0); end
      else begin nv = (pv + 1) % 65536; nw = (pv == 65535); end
      nr[2*s] = nv % 256;
      nr[2*s+1] = nv / 256;
    end
    if (mReg >= 0 && mReg / 2 != aPair) nr[mReg] = int'(mainIn);
    if (aPair >= 0) begin
      nr[2*aPair] = int'(addrIn) % 256;
      nr[2*aPair+1] = int'(addrIn) / 256;
    end
    for (int i = 0; i < NR; i++) mreg[i] = nr[i];
    mwrap = nw;
  endtask

  task automatic modelReset();
    for (int i = 0; i < NR; i++) mreg[i] = 0;
    mwrap = 0;
  endtask

  task automatic clockEdge();
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  task automatic idleInputs();
    mainLoadBar = 1; mainLoadSel = '0; mainIn = '0;
    addrLoadBar = 1; addrLoadSel = '0; addrIn = '0;
    addrStep = 0; addrDir = 0; addrStepSel = '0;
    mainAssertBar = 1; mainAssertSel = '0;
    lhsAssertBar = 1; lhsAssertSel = '0;
    rhsAssertBar = 1; rhsAssertSel = '0;
    addrAssertBar = 1; addrAssertSel = '0;
  endtask

  task automatic test_reset();
    idleInputs();
    rstBar = 0;
    modelReset();
    mainAssertBar = 0; lhsAssertBar = 0; rhsAssertBar = 0; addrAssertBar = 0;
    #12;
    for (int i = 0; i < NR; i++) begin
      mainAssertSel = SW'(i); lhsAssertSel = SW'(i); rhsAssertSel = SW'(i);
      addrAssertSel = PW'(i % NP);
      #1;
      checks++;
      if (mainOut !== 8'h00 || lhsOut !== 8'h00 || rhsOut !== 8'h00)
        begin errors++; $display("[TB] FAIL reset_reg%0d main=%h lhs=%h rhs=%h expected=00", i, mainOut, lhsOut, rhsOut); end
      checks++;
      if (addrOut !== 16'h0000 || addrWrap !== 1'b0)
        begin errors++; $display("[TB] FAIL reset_addr addr=%h wrap=%b expected=0000/0", addrOut, addrWrap); end
    end
    @(negedge clock);
    rstBar = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_main_load();
    idleInputs();
    mainLoadBar = 0; mainLoadSel = 3; mainIn = 8'hA5;
    lhsAssertBar = 0; lhsAssertSel = 3; rhsAssertBar = 0; rhsAssertSel = 3;
    #1;
    checks++;
    if (lhsOut !== 8'h00) begin errors++; $display("[TB] FAIL same_cycle_read actual=%h expected=00", lhsOut); end
    clockEdge();
    mainLoadBar = 1;
    #1;
    checks++;
    if (lhsOut !== 8'hA5 || rhsOut !== 8'hA5)
      begin errors++; $display("[TB] FAIL main_load_r3 lhs=%h rhs=%h expected=a5", lhsOut, rhsOut); end
    checks++;
    if (lhsOut !== DW'(expReg(3))) begin errors++; $display("[TB] FAIL main_load_model actual=%h expected=%h", lhsOut, expReg(3)); end
  endtask

  task automatic test_wrap();
    idleInputs();
    addrAssertBar = 0; addrAssertSel = 1;
    addrLoadBar = 0; addrLoadSel = 1; addrIn = 16'hFFFF;
    clockEdge();
    addrLoadBar = 1;
    addrStep = 1; addrDir = 0; addrStepSel = 1;
    clockEdge();
    addrStep = 0;
    checks++;
    if (addrOut !== 16'h0000 || addrWrap !== 1'b1)
      begin errors++; $display("[TB] FAIL wrap_inc addr=%h wrap=%b expected=0000/1", addrOut, addrWrap); end
    clockEdge();
    checks++;
    if (addrWrap !== 1'b0) begin errors++; $display("[TB] FAIL wrap_inc_pulse actual=%b expected=0", addrWrap); end
    addrStep = 1; addrDir = 1;
    clockEdge();
    addrStep = 0;
    checks++;
    if (addrOut !== 16'hFFFF || addrWrap !== 1'b1)
      begin errors++; $display("[TB] FAIL wrap_dec addr=%h wrap=%b expected=ffff/1", addrOut, addrWrap); end
    clockEdge();
    checks++;
    if (addrWrap !== 1'b0) begin errors++; $display("[TB] FAIL wrap_dec_pulse actual=%b expected=0", addrWrap); end
  endtask

  task automatic test_conflict();
    idleInputs();
    addrAssertBar = 0; addrAssertSel = 0; mainAssertBar = 0; mainAssertSel = 1;
    addrLoadBar = 0; addrLoadSel = 0; addrIn = 16'h1234;
    mainLoadBar = 0; mainLoadSel = 1; mainIn = 8'h77;
    addrStep = 1; addrDir = 0; addrStepSel = 0;
    clockEdge();
    idleInputs();
    addrAssertBar = 0; addrAssertSel = 0; mainAssertBar = 0; mainAssertSel = 1;
    #1;
    checks++;
    if (addrOut !== 16'h1234 || mainOut !== 8'h12 || addrWrap !== 1'b0)
      begin errors++; $display("[TB] FAIL conflict_pair0 addr=%h r1=%h wrap=%b expected=1234/12/0", addrOut, mainOut, addrWrap); end
  endtask

  task automatic test_parallel();
    idleInputs();
    addrLoadBar = 0; addrLoadSel = 0; addrIn = 16'h00FF;
    clockEdge();
    idleInputs();
    mainLoadBar = 0; mainLoadSel = 5; mainIn = 8'h10;
    addrStep = 1; addrDir = 0; addrStepSel = 0;
    clockEdge();
    idleInputs();
    addrAssertBar = 0; addrAssertSel = 0; rhsAssertBar = 0; rhsAssertSel = 5;
    #1;
    checks++;
    if (addrOut !== 16'h0100 || rhsOut !== 8'h10 || addrWrap !== 1'b0)
      begin errors++; $display("[TB] FAIL parallel pair0=%h r5=%h wrap=%b expected=0100/10/0", addrOut, rhsOut, addrWrap); end
  endtask

  task automatic test_out_of_range();
    idleInputs();
    mainLoadBar = 0; mainLoadSel = 6; mainIn = 8'hEE;
    addrLoadBar = 0; addrLoadSel = 3; addrIn = 16'hBEEF;
    addrStep = 1; addrStepSel = 3;
    clockEdge();
    mainLoadSel = 7;
    clockEdge();
    idleInputs();
    for (int i = 0; i < 8; i++) begin
      mainAssertBar = 0; mainAssertSel = SW'(i);
      lhsAssertBar = 1; lhsAssertSel = SW'(i);
      #1;
      checks++;
      if (mainOut !== DW'(expReg(i)) || lhsOut !== 8'h00)
        begin errors++; $display("[TB] FAIL range_reg%0d main=%h lhs=%h expected=%h/00", i, mainOut, lhsOut, expReg(i)); end
    end
    addrAssertBar = 0; addrAssertSel = 3;
    #1;
    checks++;
    if (addrOut !== 16'h0000 || addrWrap !== 1'b0)
      begin errors++; $display("[TB] FAIL range_pair3 addr=%h wrap=%b expected=0000/0", addrOut, addrWrap); end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int unsigned em, el, er, ea;
    for (int n = 0; n < 400; n++) begin
      mainLoadBar = 1'($urandom_range(0, 1)); mainLoadSel = SW'($urandom_range(0, 7)); mainIn = DW'($urandom);
      addrLoadBar = ($urandom_range(0, 3) != 0); addrLoadSel = PW'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: addrIn = 16'hFFFF;
        1: addrIn = 16'h0000;
        2: addrIn = 16'hFFFE;
        3: addrIn = 16'h0001;
        default: addrIn = 16'($urandom);
      endcase
      addrStep = 1'($urandom_range(0, 1)); addrDir = 1'($urandom_range(0, 1)); addrStepSel = PW'($urandom_range(0, 3));
      mainAssertBar = 1'($urandom_range(0, 1)); mainAssertSel = SW'($urandom_range(0, 7));
      lhsAssertBar = 1'($urandom_range(0, 1)); lhsAssertSel = SW'($urandom_range(0, 7));
      rhsAssertBar = 1'($urandom_range(0, 1)); rhsAssertSel = SW'($urandom_range(0, 7));
      addrAssertBar = 1'($urandom_range(0, 1)); addrAssertSel = PW'($urandom_range(0, 3));
      #1;
      em = mainAssertBar ? 0 : expReg(int'(mainAssertSel));
      el = lhsAssertBar ? 0 : expReg(int'(lhsAssertSel));
      er = rhsAssertBar ? 0 : expReg(int'(rhsAssertSel));
      ea = addrAssertBar ? 0 : expPair(int'(addrAssertSel));
      checks++;
      if (mainOut !== DW'(em) || lhsOut !== DW'(el) || rhsOut !== DW'(er))
        begin errors++; $display("[TB] FAIL rand_read%0d main=%h lhs=%h rhs=%h expected=%h/%h/%h", n, mainOut, lhsOut, rhsOut, em, el, er); end
      checks++;
      if (addrOut !== 16'(ea)) begin errors++; $display("[TB] FAIL rand_addr%0d actual=%h expected=%h", n, addrOut, ea); end
      clockEdge();
      checks++;
      if (addrWrap !== mwrap) begin errors++; $display("[TB] FAIL rand_wrap%0d actual=%b expected=%b", n, addrWrap, mwrap); end
    end
  endtask

  task automatic test_async_reset();
    idleInputs();
    addrLoadBar = 0; addrLoadSel = 2; addrIn = 16'hFFFF;
    mainLoadBar = 0; mainLoadSel = 0; mainIn = 8'h5A;
    clockEdge();
    idleInputs();
    addrStep = 1; addrDir = 0; addrStepSel = 2;
    clockEdge();
    mainAssertBar = 0; mainAssertSel = 0; lhsAssertBar = 0; lhsAssertSel = 4;
    addrAssertBar = 0; addrAssertSel = 2;
    #1;
    checks++;
    if (mainOut !== 8'h5A || addrWrap !== 1'b1)
      begin errors++; $display("[TB] FAIL pre_reset r0=%h wrap=%b expected=5a/1", mainOut, addrWrap); end
    #1;
    rstBar = 0;
    modelReset();
    #1;
    checks++;
    if (mainOut !== 8'h00 || lhsOut !== 8'h00 || addrOut !== 16'h0000 || addrWrap !== 1'b0)
      begin errors++; $display("[TB] FAIL async_reset r0=%h r4=%h pair2=%h wrap=%b expected=00/00/0000/0", mainOut, lhsOut, addrOut, addrWrap); end
    @(posedge clock); #1;
    rstBar = 1;
    idleInputs();
    mainLoadBar = 0; mainLoadSel = 2; mainIn = 8'h3C;
    clockEdge();
    mainLoadBar = 1; mainAssertBar = 0; mainAssertSel = 2;
    #1;
    checks++;
    if (mainOut !== 8'h3C) begin errors++; $display("[TB] FAIL first_edge_after_reset actual=%h expected=3c", mainOut); end
  endtask

  initial begin
    test_reset();
    test_main_load();
    test_wrap();
    test_conflict();
    test_parallel();
    test_out_of_range();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_registerfile.md
PARAM_REGISTERFILE -- requirements
Module: param_registerfile

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each general register.
REQ-002 SHALL have parameter NREGS, default 8, number of general registers; even, >= 2.
REQ-003 SHALL have parameter SEL_W, default 3, register select width; 2**SEL_W >= NREGS.
REQ-004 SHALL have parameter PSEL_W, default 2, address-pair select width; 2**PSEL_W >= NREGS/2.
REQ-005 SHALL have port CLK  input  1  single system clock, rising-edge active.
REQ-006 SHALL have port RST_bar  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port MAIN_LOAD_bar  input  1  low: write MAIN_in to register MAIN_LOAD_SEL.
REQ-008 SHALL have port MAIN_LOAD_SEL  input  SEL_W  MAIN write register select.
REQ-009 SHALL have port MAIN_in  input  DATA_W  MAIN write data.
REQ-010 SHALL have ports MAIN/LHS/RHS_ASSERT_bar  input  1 each  low: drive the selected register on the matching output.
REQ-011 SHALL have ports MAIN/LHS/RHS_ASSERT_SEL  input  SEL_W each  read selects.
REQ-012 SHALL have ports MAIN/LHS/RHS_out  output  DATA_W each  read data.
REQ-013 SHALL have port ADDR_LOAD_bar  input  1  low: write ADDR_in to pair ADDR_LOAD_SEL.
REQ-014 SHALL have port ADDR_LOAD_SEL  input  PSEL_W  address-pair write select.
REQ-015 SHALL have port ADDR_in  input  2*DATA_W  address write data.
REQ-016 SHALL have port ADDR_STEP  input  1  high: step pair ADDR_STEP_SEL.
REQ-017 SHALL have port ADDR_DIR  input  1  0 = increment, 1 = decrement.
REQ-018 SHALL have port ADDR_STEP_SEL  input  PSEL_W  pair to step.
REQ-019 SHALL have ports ADDR_ASSERT_bar / ADDR_ASSERT_SEL  input  1 / PSEL_W  drive selected pair on ADDR_out.
REQ-020 SHALL have port ADDR_out  output  2*DATA_W  address read data.
REQ-021 SHALL have port ADDR_WRAP  output  1  registered one-cycle pulse: last step wrapped.

Function
REQ-022 Pair k SHALL be {reg[2k+1], reg[2k]}; reg[2k] low byte.
REQ-023 Reads SHALL be combinational from current state; an asserted output shows the pre-edge value when the same register is written that cycle (no forwarding).
REQ-024 A de-asserted output, or a select >= NREGS (pair >= NREGS/2), SHALL drive all zeros.
REQ-025 ADDR_STEP SHALL update the pair by +1 or -1 modulo 2**(2*DATA_W) on the rising edge.
REQ-026 ADDR_WRAP SHALL go high for exactly the cycle after a step from all-ones (inc) or zero (dec), else low.
REQ-027 Write priority per edge: ADDR_LOAD over MAIN_LOAD over ADDR_STEP.
REQ-028 ADDR_LOAD and MAIN_LOAD to a byte of the same pair: ADDR_LOAD SHALL win for the whole pair; MAIN_LOAD to a different register SHALL still take effect.
REQ-029 ADDR_STEP on a pair also targeted by ADDR_LOAD or MAIN_LOAD SHALL be suppressed entirely (no partial carry, ADDR_WRAP stays low).
REQ-030 Non-conflicting MAIN_LOAD, ADDR_LOAD, ADDR_STEP SHALL all complete in one edge.
REQ-031 Out-of-range write or step selects SHALL be ignored.

Reset
REQ-032 RST_bar low SHALL immediately clear all registers and ADDR_WRAP to zero, independent of CLK, overriding any in-flight write or step.
REQ-033 The first edge after RST_bar rises SHALL operate normally.

Structure
REQ-034 No shared package; DATA_W/NREGS/SEL_W/PSEL_W SHALL be parameters only.
REQ-035 The 2*DATA_W inc/dec with wrap detect SHALL be one sub-module, addr_stepper (combinational).

Verification
REQ-036 Reset then assert all ports -> all outputs 0x00/0x0000, ADDR_WRAP 0.
REQ-037 MAIN_LOAD r3=0xA5, next cycle LHS_SEL=3, RHS_SEL=3 -> both 0xA5; same-cycle read showed 0x00.
REQ-038 ADDR_LOAD pair1=0xFFFF, step inc -> pair1 0x0000, ADDR_WRAP pulses one cycle; dec -> 0xFFFF, wrap again.
REQ-039 Same edge: ADDR_LOAD pair0=0x1234, MAIN_LOAD r1=0x77, step pair0 -> pair0 0x1234.
REQ-040 Same edge: MAIN_LOAD r5=0x10, step inc pair0=0x00FF -> r5 0x10, pair0 0x0100.
REQ-041 RST_bar low mid-cycle during step -> registers 0 before next CLK edge.
